// File: rtl/instr_encoder_loader.sv
// Program loader: encodes symbolic commands into 32-bit MIPS words and writes them
// sequentially into instruction memory, one command per handshake.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              error_q, error_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       word_c;
  logic              legal_c;

  // Mnemonic to machine-word encoding
  always_comb begin
    word_c  = 32'd0;
    legal_c = 1'b1;
    case (cmd_op)
      4'd0:    word_c = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h20};
      4'd1:    word_c = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h22};
      4'd2:    word_c = {6'h00, cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h2A};
      4'd3:    word_c = {6'h00, cmd_rs, 15'd0, 6'h08};
      4'd4:    word_c = {6'h02, cmd_target};
      4'd5:    word_c = {6'h03, cmd_target};
      4'd6:    word_c = {6'h08, cmd_rs, cmd_rt, cmd_imm};
      4'd7:    word_c = {6'h0E, cmd_rs, cmd_rt, cmd_imm};
      4'd8:    word_c = {6'h05, cmd_rs, cmd_rt, cmd_imm};
      4'd9:    word_c = {6'h04, cmd_rs, cmd_rt, cmd_imm};
      4'd10:   word_c = {6'h2B, cmd_rs, cmd_rt, cmd_imm};
      4'd11:   word_c = {6'h23, cmd_rs, cmd_rt, cmd_imm};
      default: legal_c = 1'b0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    error_d     = error_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCEPT;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (cmd_valid && cmd_ready_q) begin
          if (legal_c && (count_q < DEPTH_C)) begin
            state_d     = S_WRITE;
            last_d      = cmd_last;
            mem_addr_d  = BASE_C + count_q[ADDR_W-1:0];
            mem_wdata_d = word_c;
          end else begin
            // Illegal op or full session: command is consumed but dropped
            error_d = 1'b1;
            state_d = cmd_last ? S_DONE : S_ACCEPT;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + CNT_W'(1);
        state_d = last_q ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_ACCEPT);
    mem_wr_en_d = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      error_q     <= 1'b0;
      last_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cmd_ready_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      error_q     <= error_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cmd_ready_q <= cmd_ready_d;
      mem_wr_en_q <= mem_wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign count     = count_q;

endmodule
